// File: rtl/emul_demux_pkg.sv
// Shared types and constants for the emulated demux AXI4-Lite register block.
package emul_demux_pkg;

  typedef enum logic {
    WR_IDLE = 1'b0,
    WR_RESP = 1'b1
  } wr_state_e;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_DATA = 1'b1
  } rd_state_e;

  localparam int REG_CTRL = 0;
  localparam int REG_1    = 1;
  localparam int REG_2    = 2;
  localparam int REG_3    = 3;
  localparam int NUM_REGS = REG_3 - REG_CTRL + 1;

  localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/axil_wstrb_merge.sv
// Byte-lane merge: each byte comes from new_i when its strobe is set, else from old_i.
module axil_wstrb_merge #(
  parameter int W = 32
) (
  input  logic [W-1:0]   old_i,
  input  logic [W-1:0]   new_i,
  input  logic [W/8-1:0] strb_i,
  output logic [W-1:0]   merged_o
);

  for (genvar gi = 0; gi < W / 8; gi++) begin : g_lane
    assign merged_o[gi*8 +: 8] = strb_i[gi] ? new_i[gi*8 +: 8] : old_i[gi*8 +: 8];
  end

endmodule

// File: rtl/emul_demux_axil_regs.sv
// AXI4-Lite slave with four 32-bit software registers exported to the demux datapath.
module emul_demux_axil_regs
  import emul_demux_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                              ACLK,
  input  logic                              ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0]   slv_reg_o
);

  localparam int DW     = C_S_AXI_DATA_WIDTH;
  localparam int STRB_W = DW / 8;

  logic [DW-1:0]     regs_q [NUM_REGS];
  wr_state_e         wr_state_q;
  rd_state_e         rd_state_q;
  logic              awready_q, wready_q, aw_held_q, w_held_q, bvalid_q;
  logic [1:0]        awidx_q;
  logic [DW-1:0]     wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic              arready_q, rvalid_q;
  logic [DW-1:0]     rdata_q;

  logic              aw_hs, w_hs, wr_commit;
  logic [1:0]        wr_idx_d;
  logic [DW-1:0]     wdata_d, merged;
  logic [STRB_W-1:0] wstrb_d;

  logic unused_inputs;
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // A channel captured in an earlier cycle is used from its latch; a live handshake bypasses it.
  assign aw_hs     = (wr_state_q == WR_IDLE) && S_AXI_AWVALID && awready_q;
  assign w_hs      = (wr_state_q == WR_IDLE) && S_AXI_WVALID && wready_q;
  assign wr_idx_d  = aw_hs ? S_AXI_AWADDR[3:2] : awidx_q;
  assign wdata_d   = w_hs ? S_AXI_WDATA : wdata_q;
  assign wstrb_d   = w_hs ? S_AXI_WSTRB : wstrb_q;
  assign wr_commit = (wr_state_q == WR_IDLE) && (aw_hs || aw_held_q) && (w_hs || w_held_q);

  axil_wstrb_merge #(.W(DW)) u_merge (
    .old_i    (regs_q[wr_idx_d]),
    .new_i    (wdata_d),
    .strb_i   (wstrb_d),
    .merged_o (merged)
  );

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_state_q <= WR_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      awidx_q    <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      case (wr_state_q)
        WR_IDLE: begin
          if (wr_commit) begin
            regs_q[wr_idx_d] <= merged;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b1;
            wr_state_q <= WR_RESP;
          end else begin
            if (aw_hs) begin
              awidx_q   <= S_AXI_AWADDR[3:2];
              aw_held_q <= 1'b1;
              awready_q <= 1'b0;
            end else if (!aw_held_q) begin
              awready_q <= 1'b1;
            end
            if (w_hs) begin
              wdata_q  <= S_AXI_WDATA;
              wstrb_q  <= S_AXI_WSTRB;
              w_held_q <= 1'b1;
              wready_q <= 1'b0;
            end else if (!w_held_q) begin
              wready_q <= 1'b1;
            end
          end
        end
        WR_RESP: begin
          if (S_AXI_BREADY) begin
            bvalid_q   <= 1'b0;
            awready_q  <= 1'b1;
            wready_q   <= 1'b1;
            wr_state_q <= WR_IDLE;
          end
        end
        default: wr_state_q <= WR_IDLE;
      endcase
    end
  end

  // Reads sample regs_q before any same-edge write lands, so they return the old value.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rd_state_q <= RD_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      case (rd_state_q)
        RD_IDLE: begin
          if (S_AXI_ARVALID && arready_q) begin
            rdata_q    <= regs_q[S_AXI_ARADDR[3:2]];
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b1;
            rd_state_q <= RD_DATA;
          end else begin
            arready_q <= 1'b1;
          end
        end
        RD_DATA: begin
          if (S_AXI_RREADY) begin
            rvalid_q   <= 1'b0;
            arready_q  <= 1'b1;
            rd_state_q <= RD_IDLE;
          end
        end
        default: rd_state_q <= RD_IDLE;
      endcase
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = RESP_OKAY;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = RESP_OKAY;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_export
    assign slv_reg_o[gi*DW +: DW] = regs_q[gi];
  end

endmodule

// File: tb/tb_emul_demux_axil_regs.sv
// Directed plus randomized bench for emul_demux_axil_regs against a byte-level register model.
module tb_emul_demux_axil_regs;
  import emul_demux_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   awaddr = '0, araddr = '0;
  logic [2:0]   awprot = '0, arprot = '0;
  logic         awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic [31:0]  wdata = '0;
  logic [3:0]   wstrb = '0;
  logic         awready, wready, bvalid, arready, rvalid;
  logic [1:0]   bresp, rresp;
  logic [31:0]  rdata;
  logic [127:0] slv_reg;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] model [4];

  always #5 clk = ~clk;

  emul_demux_axil_regs dut (
    .ACLK(clk), .ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .slv_reg_o(slv_reg)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] model_vec();
    return {model[3], model[2], model[1], model[0]};
  endfunction

  function automatic void model_write(input logic [3:0] addr, input logic [31:0] d, input logic [3:0] s);
    int idx = int'(addr) / 4;
    for (int b = 0; b < 4; b++)
      if (s[b]) model[idx][b*8 +: 8] = d[b*8 +: 8];
  endfunction

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] d, input logic [3:0] s);
    bit aw_done = 0, w_done = 0, b_done = 0;
    @(negedge clk);
    awaddr = addr; awprot = 3'($urandom); awvalid = 1;
    wdata = d; wstrb = s; wvalid = 1; bready = 1;
    for (int i = 0; i < 50 && !(aw_done && w_done); i++) begin
      if (awvalid && awready) aw_done = 1;
      if (wvalid && wready) w_done = 1;
      @(negedge clk);
      if (aw_done) awvalid = 0;
      if (w_done) wvalid = 0;
    end
    check("wr_addr_data_accepted", {aw_done, w_done}, 2'b11);
    for (int i = 0; i < 50 && !b_done; i++) begin
      if (bvalid) begin
        b_done = 1;
        check("wr_bresp", bresp, RESP_OKAY);
      end
      @(negedge clk);
    end
    bready = 0;
    check("wr_bvalid_seen", b_done, 1'b1);
    model_write(addr, d, s);
    $display("write addr=%h data=%h strb=%b slv_reg=%h", addr, d, s, slv_reg);
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic [31:0] d);
    bit ar_done = 0, r_done = 0;
    d = 'x;
    @(negedge clk);
    araddr = addr; arprot = 3'($urandom); arvalid = 1; rready = 1;
    for (int i = 0; i < 50 && !ar_done; i++) begin
      if (arready) ar_done = 1;
      @(negedge clk);
    end
    arvalid = 0;
    check("rd_addr_accepted", ar_done, 1'b1);
    check("rd_latency_rvalid", rvalid, 1'b1);
    for (int i = 0; i < 50 && !r_done; i++) begin
      if (rvalid) begin
        r_done = 1;
        d = rdata;
        check("rd_rresp", rresp, RESP_OKAY);
      end
      @(negedge clk);
    end
    rready = 0;
    check("rd_rvalid_seen", r_done, 1'b1);
    $display("read  addr=%h data=%h", addr, d);
  endtask

  initial begin
    logic [31:0] rd, x, y;
    for (int i = 0; i < 4; i++) model[i] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_readies", {awready, wready, arready}, 3'b000);
    check("rst_valids", {bvalid, rvalid}, 2'b00);
    check("rst_rdata", rdata, 32'h0);
    check("rst_resps", {bresp, rresp}, 4'b0000);
    check("rst_regs", slv_reg, 128'h0);
    rst_n = 1;
    @(negedge clk);
    check("post_rst_readies", {awready, wready, arready}, 3'b111);

    // Sequential writes then reads
    for (int i = 0; i < 4; i++) axi_write(4'(i * 4), 32'(i + 1), 4'hF);
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i * 4), rd);
      check("seq_read", rd, 32'(i + 1));
    end
    check("seq_slv_reg", slv_reg, 128'h00000004_00000003_00000002_00000001);

    // W three cycles ahead of AW
    @(negedge clk);
    wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1; bready = 0;
    @(negedge clk);
    wvalid = 0;
    check("early_w_wready_drop", wready, 1'b0);
    repeat (2) begin
      check("early_w_reg2_hold", slv_reg[64 +: 32], 32'h3);
      check("early_w_no_bvalid", bvalid, 1'b0);
      @(negedge clk);
    end
    check("early_w_awready", awready, 1'b1);
    awaddr = 4'h8; awvalid = 1;
    @(negedge clk);
    awvalid = 0;
    model_write(4'h8, 32'hDEADBEEF, 4'hF);
    check("early_w_reg2_upd", slv_reg, model_vec());
    check("early_w_bvalid", bvalid, 1'b1);
    bready = 1;
    @(negedge clk);
    bready = 0;
    check("early_w_bvalid_clr", bvalid, 1'b0);
    $display("write addr=8 data=deadbeef W-before-AW slv_reg=%h", slv_reg);

    // Byte strobes
    axi_write(4'h4, 32'hAABBCCDD, 4'hF);
    axi_write(4'h5, 32'h11223344, 4'b0010);
    check("strobe_reg1", slv_reg[32 +: 32], 32'hAABB33DD);

    // BREADY held low with a second write pending
    x = $urandom; y = $urandom;
    @(negedge clk);
    awaddr = 4'hC; wdata = x; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
    @(negedge clk);
    model_write(4'hC, x, 4'hF);
    awaddr = 4'h0; wdata = y;
    repeat (5) begin
      check("bp_bvalid_held", bvalid, 1'b1);
      check("bp_readies_low", {awready, wready}, 2'b00);
      check("bp_regs_hold", slv_reg, model_vec());
      @(negedge clk);
    end
    bready = 1;
    @(negedge clk);
    bready = 0;
    check("bp_readies_back", {awready, wready}, 2'b11);
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    model_write(4'h0, y, 4'hF);
    check("bp_second_write", slv_reg, model_vec());
    check("bp_second_bvalid", bvalid, 1'b1);
    bready = 1;
    @(negedge clk);
    bready = 0;
    $display("write addr=c/0 data=%h/%h backpressure slv_reg=%h", x, y, slv_reg);

    // Read and write of reg1 on the same edge
    axi_write(4'h4, 32'h2, 4'hF);
    @(negedge clk);
    awaddr = 4'h4; wdata = 32'h55; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    araddr = 4'h4; arvalid = 1; rready = 0; bready = 0;
    @(negedge clk);
    awvalid = 0; wvalid = 0; arvalid = 0; bready = 1;
    model_write(4'h4, 32'h55, 4'hF);
    check("rw_rvalid", rvalid, 1'b1);
    check("rw_old_rdata", rdata, 32'h2);
    check("rw_reg1_new", slv_reg, model_vec());
    check("rw_bvalid", bvalid, 1'b1);
    repeat (4) begin
      @(negedge clk);
      bready = 0;
      check("rw_rdata_stable", {rvalid, rdata}, {1'b1, 32'h2});
    end
    rready = 1;
    @(negedge clk);
    rready = 0;
    check("rw_rvalid_clr", rvalid, 1'b0);
    axi_read(4'h4, rd);
    check("rw_reread", rd, 32'h55);

    // Randomized traffic against the model
    for (int t = 0; t < 40; t++) begin
      logic [3:0] a;
      a = 4'($urandom);
      if ($urandom_range(1) == 0) begin
        axi_write(a, $urandom, 4'($urandom));
        check("rnd_slv_reg", slv_reg, model_vec());
      end else begin
        axi_read(a, rd);
        check("rnd_read", rd, model[int'(a) / 4]);
      end
    end

    // Reset while BVALID is high
    @(negedge clk);
    awaddr = 4'h8; wdata = 32'hCAFEF00D; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    check("rst_mid_bvalid_before", bvalid, 1'b1);
    #2 rst_n = 0;
    #1;
    check("rst_mid_bvalid_drop", bvalid, 1'b0);
    check("rst_mid_regs", slv_reg, 128'h0);
    for (int i = 0; i < 4; i++) model[i] = '0;
    @(negedge clk);
    rst_n = 1; bready = 1; rready = 1;
    repeat (3) begin
      @(negedge clk);
      check("rst_no_spurious", {bvalid, rvalid}, 2'b00);
    end
    bready = 0; rready = 0;
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i * 4), rd);
      check("rst_read_zero", rd, model[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
